snn_timestep_scheduler: RTL and testbench
=========================================

// Module: snn_timestep_scheduler
// PURPOSE
//  Sequences one SNN inference run: pulses network reset, then per timestep fires the input
//  spike generators and steps each hidden layer in order, waiting on each layer's done.
//  Sits between the AXI config register file (ctrl/sim_time regs) and the spike-gen/layer
//  datapath; holds cfg_lock so synapse memories cannot be rewritten mid-run.
// PARAMETERS
//  NUM_LAYERS    2     number of hidden layers stepped per timestep (>=1)
//  RST_CYCLES    4     cycles net_rst is held at run start (>=1)
//  STEP_TIMEOUT  1024  max cycles waiting for one layer_done before error (0 = disabled)
// PORTS
//  S_AXI_ACLK     in   1           sole clock
//  S_AXI_ARESETN  in   1           asynchronous, active-low reset
//  ctrl_start     in   1           1-cycle pulse: begin run (from ctrl reg write)
//  ctrl_abort     in   1           1-cycle pulse: abandon run
//  sim_time       in   32          timesteps to run; sampled on accepted start
//  layer_done     in   NUM_LAYERS  per-layer 1-cycle pulse: layer finished current step
//  net_rst        out  1           synchronous reset to neurons/spike gens
//  spike_gen_tick out  1           1-cycle pulse: input spike gens produce this step's spikes
//  layer_step     out  NUM_LAYERS  one-hot level: layer i integrating current step
//  timestep       out  32          completed timestep count
//  busy           out  1           run in progress
//  done           out  1           level: last run completed; cleared on next accepted start
//  error          out  1           level: layer timeout; cleared on next accepted start
//  cfg_lock       out  1           = busy; config writes to synapse/gen regs must be blocked
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; sim_time latch 0; layer index 0.
//  - States: IDLE -> RST -> GEN -> LAYER -> ADV -> (GEN | FIN); FIN -> IDLE.
//  - IDLE: ctrl_start accepted only here; latches sim_time, clears timestep/done/error,
//    busy=1 next cycle, enters RST. Start while busy ignored.
//  - RST: net_rst=1 exactly RST_CYCLES cycles; then GEN if latched sim_time!=0, else FIN
//    (zero-length run: done=1, timestep=0, no tick/step issued).
//  - GEN: spike_gen_tick=1 for one cycle; next cycle LAYER with index 0.
//  - LAYER: layer_step[idx]=1 (only that bit); waits layer_done[idx]; on it layer_step
//    drops next cycle; idx<NUM_LAYERS-1 -> idx+1 stay LAYER, else ADV. layer_done bits for
//    other layers ignored; done arriving same cycle step rises is accepted.
//  - Timeout: cycle counter cleared on entering each layer; reaching STEP_TIMEOUT ->
//    error=1, FIN (done stays 0). Counter saturates, never wraps.
//  - ADV: timestep+=1 (one cycle); if new value == latched sim_time -> FIN else GEN.
//    Compare full 32-bit; sim_time=32'hFFFF_FFFF runs to that count without wrap.
//  - FIN: busy=0, done=1 (unless error); back to IDLE same cycle.
//  - Abort: any non-IDLE state -> IDLE next cycle; busy,layer_step,tick,net_rst=0;
//    done=0, error unchanged, timestep holds. Abort + start same cycle: abort wins.
//  - Async reset mid-run: immediate return to reset values; no completion reported.
//  - Per-timestep latency (no timeout): 1 (GEN) + sum(layer waits) + 1 (ADV) cycles.
// STRUCTURE
//  - snn_pkg: sched_state_t enum {IDLE,RST,GEN,LAYER,ADV,FIN}; CTRL_START/CTRL_ABORT
//    ctrl-reg bit indices shared with the AXI reg file.
//  - One sub-module: snn_step_watchdog (saturating counter, clear, timeout flag).
//  - FSM + counters in this module, registered outputs only.
// TESTING
//  - sim_time=3, NUM_LAYERS=2, layers answer after 5 cycles -> net_rst 4 cycles, 3 ticks,
//    layer_step order 01,10 per step, timestep 1,2,3, done=1, busy=0.
//  - sim_time=0 -> net_rst 4 cycles, no tick/layer_step, done=1, timestep=0.
//  - Abort during layer 1 of timestep 2 -> IDLE next cycle, all strobes 0, done=0,
//    timestep=1; new start then runs cleanly from 0.
//  - STEP_TIMEOUT=16, layer 0 never answers -> error=1 after 16 cycles, done=0, busy=0.
//  - ctrl_start while busy, stray layer_done[1] during layer 0 -> both ignored, run unchanged.
//  - ARESETN low mid-run -> all outputs 0 asynchronously; release -> IDLE awaiting start.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN run scheduler and the AXI control
// register file.
package snn_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE,
    RST,
    GEN,
    LAYER,
    ADV,
    FIN
  } sched_state_t;

  // Bit positions inside the ctrl register (shared with the AXI reg file)
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;

  // Width of sim_time / timestep
  localparam int unsigned TS_W = 32;

endpackage

// File: rtl/snn_step_watchdog.sv
// Saturating cycle counter that flags a layer that takes too long to finish.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear (start of a new layer wait)
//   en          counting enable (waiting on a layer)
//   timeout_c   combinational: enabled and LIMIT waiting cycles have elapsed
// LIMIT = 0 disables the timeout.
module snn_step_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  localparam int unsigned CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam int unsigned LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

  logic [CW-1:0] cnt_q;

  // Counter holds at LAST rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CW'(LAST))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The cycle with cnt_q == LAST is the LIMIT-th waiting cycle
  assign timeout_c = (LIMIT != 0) && en && (cnt_q == CW'(LAST));

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences one SNN inference run: network reset pulse, then per timestep a
// spike-generator tick followed by stepping each hidden layer in order.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, async active-low reset
//   ctrl_start, ctrl_abort     1-cycle control pulses from the ctrl register
//   sim_time                   timesteps to run, latched on accepted start
//   layer_done                 per-layer completion pulses
//   net_rst                    reset to neurons / spike generators
//   spike_gen_tick             1-cycle pulse per timestep
//   layer_step                 one-hot: layer currently integrating
//   timestep                   completed timestep count
//   busy, done, error          run status
//   cfg_lock                   blocks config writes while a run is active
module snn_timestep_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = 2,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned STEP_TIMEOUT = 1024
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic [TS_W-1:0]       sim_time,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  net_rst,
  output logic                  spike_gen_tick,
  output logic [NUM_LAYERS-1:0] layer_step,
  output logic [TS_W-1:0]       timestep,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cfg_lock
);

  localparam int unsigned IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  sched_state_t state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TS_W-1:0] sim_time_q, sim_time_d;
  logic [TS_W-1:0] timestep_q, timestep_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            wd_clr, wd_en, wd_timeout_c;

  logic                  net_rst_d, tick_d, busy_d;
  logic [NUM_LAYERS-1:0] layer_step_d;

  snn_step_watchdog #(
    .LIMIT(STEP_TIMEOUT)
  ) u_watchdog (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .clr      (wd_clr),
    .en       (wd_en),
    .timeout_c(wd_timeout_c)
  );

  // State and datapath registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      rst_cnt_q      <= '0;
      sim_time_q     <= '0;
      timestep_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      net_rst        <= 1'b0;
      spike_gen_tick <= 1'b0;
      layer_step     <= '0;
      busy           <= 1'b0;
      cfg_lock       <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rst_cnt_q      <= rst_cnt_d;
      sim_time_q     <= sim_time_d;
      timestep_q     <= timestep_d;
      done_q         <= done_d;
      error_q        <= error_d;
      net_rst        <= net_rst_d;
      spike_gen_tick <= tick_d;
      layer_step     <= layer_step_d;
      busy           <= busy_d;
      cfg_lock       <= busy_d;
    end
  end

  // Next-state logic; strobes are decoded from the next state so they are
  // registered and line up exactly with the state they belong to.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rst_cnt_d  = rst_cnt_q;
    sim_time_d = sim_time_q;
    timestep_d = timestep_q;
    done_d     = done_q;
    error_d    = error_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_start && !ctrl_abort) begin
          sim_time_d = sim_time;
          timestep_d = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          rst_cnt_d  = '0;
          state_d    = RST;
        end
      end
      RST: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          if (sim_time_q != '0) begin
            state_d = GEN;
          end else begin
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      GEN: begin
        idx_d   = '0;
        wd_clr  = 1'b1;
        state_d = LAYER;
      end
      LAYER: begin
        wd_en = 1'b1;
        // Only the active layer's done counts; completion beats a same-cycle timeout
        if (layer_done[idx_q]) begin
          if (idx_q == IW'(NUM_LAYERS - 1)) begin
            timestep_d = timestep_q + TS_W'(1);
            state_d    = ADV;
          end else begin
            idx_d  = idx_q + IW'(1);
            wd_clr = 1'b1;
          end
        end else if (wd_timeout_c) begin
          error_d = 1'b1;
          state_d = FIN;
        end
      end
      ADV: begin
        if (timestep_q == sim_time_q) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          state_d = GEN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort from any active state: error and timestep keep their values
    if (ctrl_abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      idx_d      = '0;
      timestep_d = timestep_q;
      done_d     = 1'b0;
      error_d    = error_q;
    end

    net_rst_d    = (state_d == RST);
    tick_d       = (state_d == GEN);
    layer_step_d = (state_d == LAYER) ? (NUM_LAYERS'(1) << idx_d) : '0;
    busy_d       = (state_d == RST) || (state_d == GEN) ||
                   (state_d == LAYER) || (state_d == ADV);
  end

  assign timestep = timestep_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler (NUM_LAYERS=2, RST_CYCLES=4,
// STEP_TIMEOUT=16). A responder answers each layer_step after resp_wait cycles.
module tb_snn_timestep_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_start = 1'b0;
  logic        ctrl_abort = 1'b0;
  logic [31:0] sim_time = '0;
  logic [1:0]  layer_done;
  logic        net_rst, spike_gen_tick, busy, done, error, cfg_lock;
  logic [1:0]  layer_step;
  logic [31:0] timestep;

  logic [1:0]  resp_done = '0;
  logic [1:0]  stray_done = '0;
  logic [1:0]  resp_mask = 2'b11;
  int          resp_wait = 5;
  int          rcnt [2];

  int n_cmp = 0;
  int n_err = 0;

  assign layer_done = resp_done | stray_done;

  always #5 clk = ~clk;

  snn_timestep_scheduler #(
    .NUM_LAYERS  (2),
    .RST_CYCLES  (4),
    .STEP_TIMEOUT(16)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .ctrl_start    (ctrl_start),
    .ctrl_abort    (ctrl_abort),
    .sim_time      (sim_time),
    .layer_done    (layer_done),
    .net_rst       (net_rst),
    .spike_gen_tick(spike_gen_tick),
    .layer_step    (layer_step),
    .timestep      (timestep),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .cfg_lock      (cfg_lock)
  );

  // Layer model: pulse layer_done[i] in the resp_wait-th cycle of layer_step[i]
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!layer_step[i] || !resp_mask[i]) begin
        rcnt[i]      <= 0;
        resp_done[i] <= 1'b0;
      end else begin
        rcnt[i]      <= rcnt[i] + 1;
        resp_done[i] <= ((rcnt[i] + 1) == resp_wait);
      end
    end
  end

  // Run monitor: cycle counts and compact traces of step order / timestep values
  logic        mon_clr = 1'b0;
  int          rst_cyc, tick_cyc, busy_cyc, step_cyc, multi_hot, lock_bad;
  logic [31:0] step_code, ts_code, prev_ts;
  logic [1:0]  prev_step;

  always @(negedge clk) begin
    if (mon_clr) begin
      rst_cyc   <= 0;
      tick_cyc  <= 0;
      busy_cyc  <= 0;
      step_cyc  <= 0;
      multi_hot <= 0;
      lock_bad  <= 0;
      step_code <= '0;
      ts_code   <= '0;
      prev_step <= '0;
      prev_ts   <= timestep;
    end else begin
      if (net_rst)        rst_cyc  <= rst_cyc + 1;
      if (spike_gen_tick) tick_cyc <= tick_cyc + 1;
      if (busy)           busy_cyc <= busy_cyc + 1;
      if (|layer_step)    step_cyc <= step_cyc + 1;
      if (&layer_step)    multi_hot <= multi_hot + 1;
      if (cfg_lock != busy) lock_bad <= lock_bad + 1;
      if ((layer_step != prev_step) && (layer_step != 2'b00))
        step_code <= {step_code[29:0], layer_step};
      if ((timestep != prev_ts) && (timestep != '0))
        ts_code <= {ts_code[27:0], timestep[3:0]};
      prev_step <= layer_step;
      prev_ts   <= timestep;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] st);
    mon_clear();
    @(negedge clk);
    sim_time   = st;
    ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check_eq({tag, "_end"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_step(input logic [1:0] want, input logic [31:0] ts, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((layer_step == want) && (timestep == ts)) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic check_run(input string tag, input logic [31:0] ts, input int rst_n_cyc,
                           input int ticks, input int busy_n, input logic [31:0] steps,
                           input logic [31:0] ts_trace);
    check_eq({tag, "_done"},     64'(done),      64'd1);
    check_eq({tag, "_error"},    64'(error),     64'd0);
    check_eq({tag, "_timestep"}, 64'(timestep),  64'(ts));
    check_eq({tag, "_rstcyc"},   64'(rst_cyc),   64'(rst_n_cyc));
    check_eq({tag, "_ticks"},    64'(tick_cyc),  64'(ticks));
    check_eq({tag, "_busycyc"},  64'(busy_cyc),  64'(busy_n));
    check_eq({tag, "_steps"},    64'(step_code), 64'(steps));
    check_eq({tag, "_tstrace"},  64'(ts_code),   64'(ts_trace));
    check_eq({tag, "_onehot"},   64'(multi_hot), 64'd0);
    check_eq({tag, "_lock"},     64'(lock_bad),  64'd0);
  endtask

  function automatic logic [39:0] all_outs();
    return {net_rst, spike_gen_tick, layer_step, timestep, busy, done, error, cfg_lock};
  endfunction

  initial begin
    // Reset state
    #12;
    check_eq("reset_outs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", 64'(all_outs()), 64'd0);

    // 3 timesteps, layers answer in their 5th cycle: 4 + 3*(1+5+5+1) busy cycles
    resp_wait = 5;
    start_run(32'd3);
    wait_idle(200, "run3");
    check_run("run3", 32'd3, 4, 3, 40, 32'h666, 32'h123);
    check_eq("run3_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check_eq("run3_done_hold", 64'({busy, done, timestep}), 64'({1'b0, 1'b1, 32'd3}));

    // Zero-length run: reset pulse only
    start_run(32'd0);
    wait_idle(50, "run0");
    check_run("run0", 32'd0, 4, 0, 4, 32'h0, 32'h0);

    // Layer answers in the same cycle its step rises: 4 + 2*(1+1+1+1)
    resp_wait = 1;
    start_run(32'd2);
    wait_idle(100, "fast");
    check_run("fast", 32'd2, 4, 2, 12, 32'h66, 32'h12);

    // Abort while layer 1 of timestep 2 is integrating
    resp_wait = 5;
    start_run(32'd5);
    wait_step(2'b10, 32'd1, "abort");
    ctrl_abort = 1'b1;
    @(negedge clk);
    ctrl_abort = 1'b0;
    #1;
    check_eq("abort_outs", 64'(all_outs()), 64'({1'b0, 1'b0, 2'b00, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0}));
    // Abort and start together in IDLE: abort wins, nothing starts
    @(negedge clk);
    ctrl_start = 1'b1;
    ctrl_abort = 1'b1;
    sim_time   = 32'd4;
    @(negedge clk);
    ctrl_start = 1'b0;
    ctrl_abort = 1'b0;
    check_eq("abort_start_busy", 64'({busy, net_rst}), 64'd0);
    start_run(32'd2);
    wait_idle(200, "after_abort");
    check_run("after_abort", 32'd2, 4, 2, 28, 32'h66, 32'h12);

    // Start while busy and a stray layer_done[1] during layer 0 are ignored
    start_run(32'd2);
    wait_step(2'b01, 32'd0, "stray");
    ctrl_start = 1'b1;
    sim_time   = 32'd9;
    stray_done = 2'b10;
    @(negedge clk);
    ctrl_start = 1'b0;
    stray_done = 2'b00;
    wait_idle(200, "stray");
    check_run("stray", 32'd2, 4, 2, 28, 32'h66, 32'h12);

    // Layer 0 never answers: 16 step cycles then error, no done
    resp_mask = 2'b10;
    start_run(32'd3);
    wait_idle(100, "tmo");
    check_eq("tmo_err",     64'({error, done, busy}), 64'({1'b1, 1'b0, 1'b0}));
    check_eq("tmo_stepcyc", 64'(step_cyc), 64'd16);
    check_eq("tmo_busycyc", 64'(busy_cyc), 64'd21);
    check_eq("tmo_ts",      64'(timestep), 64'd0);
    @(negedge clk);
    check_eq("tmo_err_hold", 64'({error, busy}), 64'({1'b1, 1'b0}));
    resp_mask = 2'b11;
    start_run(32'd1);
    check_eq("tmo_err_clr", 64'({error, busy}), 64'({1'b0, 1'b1}));
    wait_idle(100, "post_tmo");
    check_run("post_tmo", 32'd1, 4, 1, 16, 32'h6, 32'h1);

    // Asynchronous reset mid-run
    start_run(32'd3);
    wait_step(2'b01, 32'd0, "areset");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("areset_outs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("areset_idle", 64'(all_outs()), 64'd0);
    start_run(32'd1);
    wait_idle(100, "post_rst");
    check_run("post_rst", 32'd1, 4, 1, 16, 32'h6, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
